// File: rtl/alu8_seq.sv
// alu8_seq: 8-bit ALU operation sequenced over two passes through one external
// 4-bit alu4 slice (low nibble, then high nibble), with registered result and
// C/Z/N/V flags. One operation takes four cycles: IDLE -> LO -> HI -> FIN.
module alu8_seq #(
    parameter bit V_ON_LOGIC = 1'b0
) (
    input  logic [4:0] LOGISIM_CLOCK_TREE_0,
    input  logic       RESET,
    input  logic       START,
    input  logic [2:0] OP,
    input  logic [7:0] A_IN,
    input  logic [7:0] B_IN,
    input  logic       C_IN,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] R,
    output logic       FLAG_C,
    output logic       FLAG_Z,
    output logic       FLAG_N,
    output logic       FLAG_V,
    output logic [3:0] ALU_A,
    output logic [3:0] ALU_B,
    output logic [3:0] ALU_S,
    output logic       ALU_M,
    output logic       ALU_CI,
    input  logic [3:0] ALU_F,
    input  logic       ALU_CO
);

    localparam logic [2:0] OP_ADC = 3'd0;
    localparam logic [2:0] OP_SBC = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_ORA = 3'd3;
    localparam logic [2:0] OP_EOR = 3'd4;
    localparam logic [2:0] OP_INC = 3'd5;
    localparam logic [2:0] OP_DEC = 3'd6;
    localparam logic [2:0] OP_CMP = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        FIN  = 2'd3
    } state_t;

    // Only bit 4 of the clock tree is a real clock; the rest are tied off upstream.
    logic clk;
    logic unused_clk_bits;
    assign clk             = LOGISIM_CLOCK_TREE_0[4];
    assign unused_clk_bits = ^LOGISIM_CLOCK_TREE_0[3:0];

    state_t     state, state_nxt;
    logic [7:0] a_q, b_q;
    logic       c_q;
    logic [2:0] op_q;
    logic [3:0] lo_q;
    logic       cy_q;

    // Slice function select for each operation.
    function automatic logic [3:0] op_sel(input logic [2:0] op);
        case (op)
            OP_ADC:  op_sel = 4'b1001;
            OP_SBC:  op_sel = 4'b0110;
            OP_AND:  op_sel = 4'b1011;
            OP_ORA:  op_sel = 4'b1110;
            OP_EOR:  op_sel = 4'b0110;
            OP_INC:  op_sel = 4'b0000;
            OP_DEC:  op_sel = 4'b1111;
            default: op_sel = 4'b0110;
        endcase
    endfunction

    // Slice mode: 1 = arithmetic, 0 = logic.
    function automatic logic op_mode(input logic [2:0] op);
        op_mode = !(op == OP_AND || op == OP_ORA || op == OP_EOR);
    endfunction

    // Carry into the low nibble pass.
    function automatic logic op_cin(input logic [2:0] op, input logic c);
        case (op)
            OP_ADC, OP_SBC: op_cin = c;
            OP_INC, OP_CMP: op_cin = 1'b1;
            default:        op_cin = 1'b0;
        endcase
    endfunction

    // Full 8-bit result as seen during HI, plus the two overflow candidates.
    logic [7:0] res_full;
    logic       v_add, v_sub;
    assign res_full = {ALU_F, lo_q};
    assign v_add    = ~(a_q[7] ^ b_q[7]) & (a_q[7] ^ res_full[7]);
    assign v_sub    =  (a_q[7] ^ b_q[7]) & (a_q[7] ^ res_full[7]);

    // State register; reset dominates everything.
    always_ff @(posedge clk) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: START is only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (START) state_nxt = LO;
            LO:      state_nxt = HI;
            HI:      state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: status strobes and slice drive, slice inputs zero outside LO/HI.
    always_comb begin
        BUSY   = 1'b0;
        DONE   = 1'b0;
        ALU_A  = 4'd0;
        ALU_B  = 4'd0;
        ALU_S  = 4'd0;
        ALU_M  = 1'b0;
        ALU_CI = 1'b0;
        case (state)
            LO: begin
                BUSY   = 1'b1;
                ALU_A  = a_q[3:0];
                ALU_B  = b_q[3:0];
                ALU_S  = op_sel(op_q);
                ALU_M  = op_mode(op_q);
                ALU_CI = op_cin(op_q, c_q);
            end
            HI: begin
                BUSY   = 1'b1;
                ALU_A  = a_q[7:4];
                ALU_B  = b_q[7:4];
                ALU_S  = op_sel(op_q);
                ALU_M  = op_mode(op_q);
                ALU_CI = cy_q;
            end
            FIN:     DONE = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, nibble/carry latching and result/flag update.
    always_ff @(posedge clk) begin
        if (RESET) begin
            a_q    <= 8'd0;
            b_q    <= 8'd0;
            c_q    <= 1'b0;
            op_q   <= 3'd0;
            lo_q   <= 4'd0;
            cy_q   <= 1'b0;
            R      <= 8'd0;
            FLAG_C <= 1'b0;
            FLAG_Z <= 1'b0;
            FLAG_N <= 1'b0;
            FLAG_V <= 1'b0;
        end else begin
            case (state)
                IDLE: if (START) begin
                    a_q  <= A_IN;
                    b_q  <= B_IN;
                    c_q  <= C_IN;
                    op_q <= OP;
                end
                LO: begin
                    lo_q <= ALU_F;
                    cy_q <= ALU_CO;
                end
                HI: begin
                    FLAG_Z <= (res_full == 8'd0);
                    FLAG_N <= res_full[7];
                    case (op_q)
                        OP_ADC: begin
                            R      <= res_full;
                            FLAG_C <= ALU_CO;
                            FLAG_V <= v_add;
                        end
                        OP_SBC: begin
                            R      <= res_full;
                            FLAG_C <= ALU_CO;
                            FLAG_V <= v_sub;
                        end
                        // Compare only touches flags; the difference is discarded.
                        OP_CMP: FLAG_C <= ALU_CO;
                        default: begin
                            R <= res_full;
                            if (V_ON_LOGIC) FLAG_V <= 1'b0;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
